uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, next generation of the fixed 8N1 transmit path. Configurable data width, parity mode and stop-bit count. Built-in rising-edge detection of the start request and a one-deep holding register, so one byte can be queued while another is shifting out. Sits between the host/button logic and the serial pin; replaces the separate one-shot plus transmitter pair.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range ≥1.
DATA_BITS, 8, data bits per frame; legal range 5..9, sent LSB first.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous reset, active-high.
i_Tx_DV  input  1  transmit request (level); only a 0→1 transition requests a send.
i_Tx_Byte  input  DATA_BITS  data; sampled on the same clk edge as the request edge.
o_Tx_Ready  output  1  high when the holding register is empty.
o_Tx_Active  output  1  high while a frame is on the line.
o_Tx_Serial  output  1  serial line; idles high.
o_Tx_Done  output  1  one-cycle pulse at the end of each frame.
o_Tx_Overrun  output  1  sticky; a request was lost.

Behaviour:
- Reset (sync, wins over everything): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Tx_Overrun=0; FSM=IDLE; counters and edge-detect history cleared, with history=0.
- Request edge: i_Tx_DV=1 at edge k and 0 at edge k-1. A level held high makes exactly one request. Edge history is registered every cycle.
- On a request edge with holding empty: latch i_Tx_Byte into holding; Ready falls after edge k.
- On a request edge with holding full: drop the byte, set Overrun. Holding content is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE, holding valid: on the next edge go to START, drive Serial=0, Active=1, move holding into the shifter, Ready=1. Serial therefore falls on edge k+1.
- Each state lasts CLKS_PER_BIT cycles, timed by a baud counter from 0 to CLKS_PER_BIT-1. The counter is cleared on every state or bit change.
- DATA: shift out DATA_BITS bits, LSB first, counted by a bit counter.
- After DATA: go to PARITY if PARITY≠0, otherwise STOP.
- PARITY bit: even mode sends XOR of the data bits; odd mode sends its inverse.
- STOP: Serial=1 for STOP_BITS×CLKS_PER_BIT cycles.
- Frame length is (1+DATA_BITS+(PARITY≠0)+STOP_BITS)×CLKS_PER_BIT cycles.
- End of STOP: pulse Done for one cycle on the same edge the frame ends.
  - Holding empty: go to IDLE with Active=0.
  - Holding valid: go straight to START with no idle cycle; Active stays 1.
- Request edge on the same edge the shifter loads from holding: the new byte is accepted, because holding empties and refills on the same edge. Ready stays 0.
- Reset mid-frame: the line returns high on the next edge and the partial frame is abandoned. No Done pulse.
- i_Tx_Byte is ignored except on request edges.

Decomposition:
- Package uart_pkg: state enum (IDLE/START/DATA/PARITY/STOP), parity codes PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2, and a frame-length function.
- Sub-module uart_tx_baud_gen: baud counter with a clear input and a bit_tick output. Its counter width is $clog2(CLKS_PER_BIT) with a minimum of 1.
- FSM, holding register and edge detect stay in uart_tx_frame.

Test Plan:
1. Defaults (CLKS_PER_BIT=4, 8N1), send 0xA5 with i_Tx_DV held high for 20 cycles → one frame of 40 cycles. Serial bits: 0,1,0,1,0,0,1,0,1,1, each 4 cycles. Done pulses once, Active falls the same cycle.
2. PARITY=2, then PARITY=1, send 0xA5 → parity bit 0 (even mode), then 1 (odd mode). Frame is 44 cycles.
3. DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=1, send 0x13 → Serial 0,1,1,0,0,1,1,1. Frame is 8 cycles.
4. Back-to-back: request 0x55, then 0x0F while the first is in DATA → second START immediately follows the first STOP. Done pulses twice, 40 cycles apart. Active never drops. Overrun=0.
5. Overrun: three requests in quick succession during the first frame → third is dropped, Overrun=1 and sticky. Only 2 frames are sent.
6. Reset asserted mid-DATA → next cycle Serial=1, Active=0, Ready=1, Overrun=0, no Done. A new request then sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared transmitter states, parity codes and frame length helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  function automatic int frame_len(input int cpb, input int data_bits, input int parity, input int stop_bits);
    return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * cpb;
  endfunction
endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: per-bit cycle counter, bit_tick on the last cycle of each bit
module uart_tx_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt;
  assign bit_tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clear || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with request edge detect and one-deep holding register
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Overrun
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  state_t state, state_n;
  logic [3:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] hold, hold_n, shift, shift_n;
  logic hold_v, hold_v_n, par, par_n, serial_n, active_n, done_n, ovr_n;
  logic dv_prev, bit_tick, load, req, accept;
  uart_tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(reset),
    .clear(state == S_IDLE),
    .bit_tick(bit_tick)
  );
  always_comb begin
    req = i_Tx_DV && !dv_prev;
    state_n = state;
    bit_n = bit_cnt;
    shift_n = shift;
    par_n = par;
    serial_n = o_Tx_Serial;
    active_n = o_Tx_Active;
    done_n = 1'b0;
    load = 1'b0;
    case (state)
      S_IDLE: load = hold_v;
      S_START: if (bit_tick) begin
        state_n = S_DATA;
        serial_n = shift[0];
      end
      S_DATA: if (bit_tick) begin
        if (bit_cnt == LAST_DATA) begin
          state_n = PARITY != PAR_NONE ? S_PARITY : S_STOP;
          bit_n = '0;
          serial_n = PARITY != PAR_NONE ? par : 1'b1;
        end else begin
          bit_n = bit_cnt + 1'b1;
          shift_n = shift >> 1;
          serial_n = shift[1];
        end
      end
      S_PARITY: if (bit_tick) begin
        state_n = S_STOP;
        serial_n = 1'b1;
      end
      S_STOP: if (bit_tick) begin
        if (bit_cnt == LAST_STOP) begin
          done_n = 1'b1;
          bit_n = '0;
          load = hold_v;
          state_n = hold_v ? S_START : S_IDLE;
          active_n = hold_v;
        end else begin
          bit_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      state_n = S_START;
      bit_n = '0;
      shift_n = hold;
      par_n = ^hold ^ (PARITY == PAR_ODD);
      serial_n = 1'b0;
      active_n = 1'b1;
    end
    accept = req && (!hold_v || load);
    hold_v_n = accept || (hold_v && !load);
    hold_n = accept ? i_Tx_Byte : hold;
    ovr_n = o_Tx_Overrun || (req && hold_v && !load);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      shift <= '0;
      hold <= '0;
      hold_v <= 1'b0;
      par <= 1'b0;
      dv_prev <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done <= 1'b0;
      o_Tx_Overrun <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      hold <= hold_n;
      hold_v <= hold_v_n;
      par <= par_n;
      dv_prev <= i_Tx_DV;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done <= done_n;
      o_Tx_Overrun <= ovr_n;
    end
  end
  assign o_Tx_Ready = !hold_v;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench over four parameterisations of uart_tx_frame
module tb_uart_tx_frame;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic dv [4];
  logic [7:0] byte8 [3];
  logic [4:0] byte5;
  logic rdy [4], act [4], ser [4], dn [4], ovr [4];
  uart_tx_frame #(.CLKS_PER_BIT(4)) u0 (
    .clk(clk), .reset(reset), .i_Tx_DV(dv[0]), .i_Tx_Byte(byte8[0]), .o_Tx_Ready(rdy[0]),
    .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(dn[0]), .o_Tx_Overrun(ovr[0]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(2)) u1 (
    .clk(clk), .reset(reset), .i_Tx_DV(dv[1]), .i_Tx_Byte(byte8[1]), .o_Tx_Ready(rdy[1]),
    .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(dn[1]), .o_Tx_Overrun(ovr[1]));
  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY(1)) u2 (
    .clk(clk), .reset(reset), .i_Tx_DV(dv[2]), .i_Tx_Byte(byte8[2]), .o_Tx_Ready(rdy[2]),
    .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(dn[2]), .o_Tx_Overrun(ovr[2]));
  uart_tx_frame #(.CLKS_PER_BIT(1), .DATA_BITS(5), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .i_Tx_DV(dv[3]), .i_Tx_Byte(byte5), .o_Tx_Ready(rdy[3]),
    .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(dn[3]), .o_Tx_Overrun(ovr[3]));
  typedef struct {int idx; int len; logic [63:0] pat;} exp_t;
  typedef struct {logic [127:0] name; logic [63:0] got; logic [63:0] want;} chk_t;
  exp_t sbq [$];
  chk_t cq [$];
  int cpb_of [4] = '{4, 4, 4, 1};
  int nvec = 0, nfail = 0, cyc = 0;
  int done_cnt [4] = '{0, 0, 0, 0};
  int last_done [4] = '{0, 0, 0, 0};
  int prev_done [4] = '{0, 0, 0, 0};
  logic done_act [4] = '{0, 0, 0, 0};
  logic [63:0] cap [4] = '{0, 0, 0, 0};
  int ccnt [4] = '{0, 0, 0, 0};
  exp_t me;
  chk_t mc;
  task automatic push_exp(input int idx, input int nbits, input logic [15:0] bits);
    exp_t e;
    e.idx = idx;
    e.len = nbits * cpb_of[idx];
    e.pat = '0;
    for (int i = nbits - 1; i >= 0; i--)
      for (int j = 0; j < cpb_of[idx]; j++) e.pat = {e.pat[62:0], bits[i]};
    sbq.push_back(e);
  endtask
  task automatic post(input logic [127:0] name, input logic [63:0] got, input logic [63:0] want);
    chk_t c;
    c.name = name;
    c.got = got;
    c.want = want;
    cq.push_back(c);
  endtask
  always @(negedge clk) begin
    cyc++;
    while (cq.size() > 0) begin
      mc = cq.pop_front();
      nvec++;
      if (mc.got !== mc.want) begin
        nfail++;
        $display("FAIL %0s got %0h required %0h", mc.name, mc.got, mc.want);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (dn[i]) begin
        done_cnt[i]++;
        prev_done[i] = last_done[i];
        last_done[i] = cyc;
        done_act[i] = act[i];
        nvec++;
        if (sbq.size() == 0) begin
          nfail++;
          $display("FAIL frame_unexpected inst %0d got len %0d pat %0h required no frame", i, ccnt[i], cap[i]);
        end else begin
          me = sbq.pop_front();
          if (me.idx != i || ccnt[i] != me.len || cap[i] != me.pat) begin
            nfail++;
            $display("FAIL frame inst %0d got len %0d pat %0h required inst %0d len %0d pat %0h",
                     i, ccnt[i], cap[i], me.idx, me.len, me.pat);
          end
        end
        cap[i] = '0;
        ccnt[i] = 0;
      end
      if (act[i]) begin
        cap[i] = {cap[i][62:0], ser[i]};
        ccnt[i]++;
      end else begin
        cap[i] = '0;
        ccnt[i] = 0;
      end
    end
  end
  task automatic pulse(input int i, input logic [7:0] b, input int hold);
    @(negedge clk);
    if (i == 3) byte5 = b[4:0];
    else byte8[i] = b;
    dv[i] = 1'b1;
    @(negedge clk);
    post("ready_fall", 64'(rdy[i]), 0);
    repeat (hold - 1) @(negedge clk);
    dv[i] = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 300 && sbq.size() != 0; n++) @(negedge clk);
    post("sb_drain", 64'(sbq.size()), 0);
    repeat (3) @(negedge clk);
  endtask
  int base;
  initial begin
    for (int i = 0; i < 4; i++) dv[i] = 1'b0;
    for (int i = 0; i < 3; i++) byte8[i] = 8'h00;
    byte5 = 5'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      post("rst_ready", 64'(rdy[i]), 1);
      post("rst_serial", 64'(ser[i]), 1);
      post("rst_active", 64'(act[i]), 0);
      post("rst_done", 64'(dn[i]), 0);
      post("rst_overrun", 64'(ovr[i]), 0);
    end
    reset = 1'b0;
    push_exp(0, 10, 10'b0101001011);
    pulse(0, 8'hA5, 20);
    drain();
    post("t1_done_cnt", 64'(done_cnt[0]), 1);
    post("t1_act_at_done", 64'(done_act[0]), 0);
    push_exp(1, 11, 11'b01010010101);
    pulse(1, 8'hA5, 2);
    drain();
    push_exp(2, 11, 11'b01010010111);
    pulse(2, 8'hA5, 2);
    drain();
    push_exp(3, 8, 8'b01100111);
    pulse(3, 8'h13, 2);
    drain();
    post("t3_done_cnt", 64'(done_cnt[3]), 1);
    push_exp(0, 10, 10'b0101010101);
    push_exp(0, 10, 10'b0111100001);
    pulse(0, 8'h55, 1);
    repeat (8) @(negedge clk);
    pulse(0, 8'h0F, 1);
    drain();
    post("t4_done_cnt", 64'(done_cnt[0]), 3);
    post("t4_done_gap", 64'(last_done[0] - prev_done[0]), 40);
    post("t4_overrun", 64'(ovr[0]), 0);
    push_exp(0, 10, 10'b0001111001);
    push_exp(0, 10, 10'b0110000111);
    pulse(0, 8'h3C, 1);
    repeat (4) @(negedge clk);
    pulse(0, 8'hC3, 1);
    repeat (2) @(negedge clk);
    pulse(0, 8'h99, 1);
    post("t5_overrun_set", 64'(ovr[0]), 1);
    drain();
    post("t5_overrun_held", 64'(ovr[0]), 1);
    post("t5_done_cnt", 64'(done_cnt[0]), 5);
    pulse(0, 8'hFF, 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    post("t6_serial", 64'(ser[0]), 1);
    post("t6_active", 64'(act[0]), 0);
    post("t6_ready", 64'(rdy[0]), 1);
    post("t6_overrun", 64'(ovr[0]), 0);
    post("t6_done", 64'(dn[0]), 0);
    reset = 1'b0;
    base = done_cnt[0];
    repeat (50) @(negedge clk);
    post("t6_no_done", 64'(done_cnt[0]), 64'(base));
    push_exp(0, 10, 10'b0101001011);
    pulse(0, 8'hA5, 1);
    drain();
    post("t6_new_frame", 64'(done_cnt[0]), 64'(base + 1));
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
